bus_booking_server: RTL and testbench
=====================================

BUS_BOOKING_SERVER -- requirements
Module: bus_booking_server

Interface
REQ-001 Parameter NSEATS, default 16: number of bookable seats, indexed 0..NSEATS-1.
REQ-002 Parameter PAY_TIMEOUT, default 8: maximum number of HOLD cycles allowed before payment.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  booking request from the customer side; sampled only in IDLE.
REQ-006 seat_id  input  4  requested seat index; latched with req.
REQ-007 pay_ok  input  1  payment-complete strobe; honoured only in HOLD.
REQ-008 cancel  input  1  customer abort; honoured only in HOLD.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 confirm  output  1  one-cycle pulse: booking completed.
REQ-011 reject  output  1  one-cycle pulse: seat unavailable or index out of range.
REQ-012 timeout  output  1  one-cycle pulse: hold released for lack of payment.
REQ-013 seat_map  output  NSEATS  bit i = 1 means seat i is held or booked.
REQ-014 seats_free  output  5  count of zero bits in seat_map.

Function
REQ-015 The FSM SHALL have six states: IDLE, CHECK, HOLD, CONFIRM, REJECT, RELEASE.
REQ-016 Outputs busy, confirm, reject and timeout SHALL be Moore decodes of the state register.
REQ-017 IDLE: req=1 SHALL latch seat_id and move to CHECK on the next edge. req=0 SHALL stay in IDLE.
REQ-018 CHECK: the FSM SHALL stay one cycle.
- If the latched index < NSEATS and its seat_map bit = 0: set the bit, decrement seats_free, load the timer with PAY_TIMEOUT, go to HOLD.
- Otherwise: go to REJECT.
REQ-019 HOLD priority, highest first:
- cancel=1: go to RELEASE, no timeout flag.
- pay_ok=1: go to CONFIRM.
- Timer = 1: go to RELEASE, timeout flag set.
- Otherwise: decrement the timer and stay in HOLD.
REQ-020 HOLD SHALL last at most PAY_TIMEOUT cycles. pay_ok in the final HOLD cycle SHALL still give CONFIRM.
REQ-021 CONFIRM: assert confirm for one cycle, keep the seat bit set, go to IDLE.
REQ-022 REJECT: assert reject for one cycle, leave seat_map and seats_free unchanged, go to IDLE.
REQ-023 RELEASE: clear the latched seat bit, increment seats_free, assert timeout only if the timeout flag is set, go to IDLE.
REQ-024 req, pay_ok and cancel SHALL be ignored in any state where this section does not list them.
REQ-025 Latency SHALL be:
- req sampled at edge N: CHECK in cycle N+1; HOLD or REJECT from cycle N+2.
- pay_ok sampled at edge M: confirm high in cycle M+1.
REQ-026 seats_free SHALL never underflow or overflow. When seats_free = 0, every request SHALL end in REJECT.
REQ-027 Booked seats SHALL persist until reset; there is no un-book path.
REQ-028 At most one of confirm, reject and timeout SHALL be high in any cycle.

Reset
REQ-029 rst=1 SHALL immediately force:
- state = IDLE
- seat_map = 0
- seats_free = NSEATS
- timer = 0
- busy, confirm, reject, timeout = 0
REQ-030 Reset asserted mid-operation, including in HOLD, SHALL discard the pending booking and all prior bookings.
REQ-031 The first request SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-032 Reset, then idle 3 cycles -> seat_map=0, seats_free=16, busy=0, all pulses 0.
REQ-033 req with seat_id=3; pay_ok in the 2nd HOLD cycle -> confirm high exactly 1 cycle, seat_map=0x0008, seats_free=15, busy back to 0.
REQ-034 req with seat_id=3 again -> reject high 1 cycle, seat_map=0x0008, seats_free=15. Also drive pay_ok=1 throughout -> no confirm.
REQ-035 req with seat_id=5, no pay_ok -> HOLD lasts exactly 8 cycles, then timeout pulses 1 cycle. seat_map=0x0008 after RELEASE; seats_free reads 14 during HOLD and 15 afterwards.
REQ-036 req with seat_id=7; cancel=1 and pay_ok=1 in the same HOLD cycle -> RELEASE, no confirm, no timeout, seat 7 freed.
REQ-037 Two cases:
- Book all 16 seats, then req seat 0 -> reject, seats_free stays 0.
- Separately, assert rst in the 4th HOLD cycle -> immediate IDLE, seat_map=0, seats_free=16.

Source files
------------

// File: rtl/bus_booking_server.sv
// Seat booking controller: a request checks a seat, holds it while payment is awaited,
// then confirms, rejects or releases it. Booked seats persist until reset.
module bus_booking_server #(
    parameter int unsigned NSEATS      = 16,
    parameter int unsigned PAY_TIMEOUT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [3:0]        seat_id_i,
    input  logic              pay_ok_i,
    input  logic              cancel_i,
    output logic              busy_o,
    output logic              confirm_o,
    output logic              reject_o,
    output logic              timeout_o,
    output logic [NSEATS-1:0] seat_map_o,
    output logic [4:0]        seats_free_o
);

    localparam int unsigned TW = $clog2(PAY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StHold,
        StConfirm,
        StReject,
        StRelease
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        seat_q, seat_d;
    logic [NSEATS-1:0] seat_map_q, seat_map_d;
    logic [4:0]        seats_free_q, seats_free_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              to_flag_q, to_flag_d;
    logic              seat_ok;

    // Out-of-range index short-circuits before the map lookup matters.
    assign seat_ok = (32'(seat_q) < NSEATS) && !seat_map_q[seat_q] && (seats_free_q != 5'd0);

    always_comb begin
        state_d      = state_q;
        seat_d       = seat_q;
        seat_map_d   = seat_map_q;
        seats_free_d = seats_free_q;
        timer_d      = timer_q;
        to_flag_d    = to_flag_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    seat_d  = seat_id_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (seat_ok) begin
                    seat_map_d[seat_q] = 1'b1;
                    seats_free_d       = seats_free_q - 5'd1;
                    timer_d            = TW'(PAY_TIMEOUT);
                    to_flag_d          = 1'b0;
                    state_d            = StHold;
                end else begin
                    state_d = StReject;
                end
            end
            StHold: begin
                if (cancel_i) begin
                    to_flag_d = 1'b0;
                    state_d   = StRelease;
                end else if (pay_ok_i) begin
                    state_d = StConfirm;
                end else if (timer_q == TW'(1)) begin
                    to_flag_d = 1'b1;
                    state_d   = StRelease;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StConfirm: state_d = StIdle;
            StReject:  state_d = StIdle;
            StRelease: begin
                seat_map_d[seat_q] = 1'b0;
                if (seats_free_q != 5'(NSEATS)) begin
                    seats_free_d = seats_free_q + 5'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            seat_q       <= 4'd0;
            seat_map_q   <= '0;
            seats_free_q <= 5'(NSEATS);
            timer_q      <= '0;
            to_flag_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            seat_q       <= seat_d;
            seat_map_q   <= seat_map_d;
            seats_free_q <= seats_free_d;
            timer_q      <= timer_d;
            to_flag_q    <= to_flag_d;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign confirm_o    = (state_q == StConfirm);
    assign reject_o     = (state_q == StReject);
    assign timeout_o    = (state_q == StRelease) && to_flag_q;
    assign seat_map_o   = seat_map_q;
    assign seats_free_o = seats_free_q;

endmodule

// File: tb/tb_bus_booking_server.sv
// Bench for bus_booking_server: directed scenarios plus randomized bookings checked
// against a transaction-level model of seat ownership and hold outcome.
module tb_bus_booking_server;

    localparam int NSEATS      = 16;
    localparam int PAY_TIMEOUT = 8;

    logic        clk, rst, req, pay_ok, cancel;
    logic [3:0]  seat_id;
    logic        busy, confirm, reject, timeout;
    logic [15:0] seat_map;
    logic [4:0]  seats_free;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_map = '0;

    bus_booking_server #(
        .NSEATS      (NSEATS),
        .PAY_TIMEOUT (PAY_TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .seat_id_i    (seat_id),
        .pay_ok_i     (pay_ok),
        .cancel_i     (cancel),
        .busy_o       (busy),
        .confirm_o    (confirm),
        .reject_o     (reject),
        .timeout_o    (timeout),
        .seat_map_o   (seat_map),
        .seats_free_o (seats_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit e_busy, input bit e_conf, input bit e_rej,
                           input bit e_tmo, input logic [15:0] e_map);
        chk({tag, ".busy"},    32'(busy),       32'(e_busy));
        chk({tag, ".confirm"}, 32'(confirm),    32'(e_conf));
        chk({tag, ".reject"},  32'(reject),     32'(e_rej));
        chk({tag, ".timeout"}, 32'(timeout),    32'(e_tmo));
        chk({tag, ".map"},     32'(seat_map),   32'(e_map));
        chk({tag, ".free"},    32'(seats_free), 32'(NSEATS - $countones(e_map)));
    endtask

    // pay_at / cancel_at: 1-based HOLD cycle in which the strobe is driven, 0 = never.
    task automatic transact(input int seat, input int pay_at, input int cancel_at,
                            input bit pay_always);
        logic [15:0] held;
        bit          acc, conf, tmo;
        int          k;
        acc     = !model_map[seat];
        req     = 1'b1;
        seat_id = 4'(seat);
        pay_ok  = 1'($urandom_range(0, 1));
        cancel  = 1'($urandom_range(0, 1));
        step();
        chk_out("check", 1, 0, 0, 0, model_map);
        req    = 1'($urandom_range(0, 1));
        pay_ok = pay_always ? 1'b1 : 1'($urandom_range(0, 1));
        cancel = 1'($urandom_range(0, 1));
        if (!acc) begin
            step();
            chk_out("reject", 1, 0, 1, 0, model_map);
            req    = 1'b0;
            pay_ok = pay_always;
            cancel = 1'b0;
            step();
            chk_out("reject_idle", 0, 0, 0, 0, model_map);
            pay_ok = 1'b0;
            return;
        end
        held = model_map | (16'd1 << seat);
        k    = PAY_TIMEOUT;
        if (pay_at > 0 && pay_at <= k) k = pay_at;
        if (cancel_at > 0 && cancel_at <= k) k = cancel_at;
        conf = (pay_at == k) && (cancel_at != k);
        tmo  = !conf && (cancel_at != k);
        for (int h = 1; h <= k; h++) begin
            step();
            chk_out("hold", 1, 0, 0, 0, held);
            req    = 1'($urandom_range(0, 1));
            pay_ok = (pay_at == h);
            cancel = (cancel_at == h);
        end
        step();
        if (conf) begin
            model_map = held;
            chk_out("confirm", 1, 1, 0, 0, model_map);
        end else begin
            chk_out("release", 1, 0, 0, tmo, held);
        end
        req    = 1'b0;
        pay_ok = 1'b0;
        cancel = 1'b0;
        step();
        chk_out("done_idle", 0, 0, 0, 0, model_map);
    endtask

    initial begin
        rst     = 1'b1;
        req     = 1'b0;
        pay_ok  = 1'b0;
        cancel  = 1'b0;
        seat_id = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("idle3", 0, 0, 0, 0, 16'h0000);
        end

        transact(3, 2, 0, 0);
        chk("seat3_map", 32'(seat_map), 32'h0008);
        transact(3, 0, 0, 1);
        transact(5, 0, 0, 0);
        chk("seat5_map", 32'(seat_map), 32'h0008);
        transact(7, 2, 2, 0);
        transact(6, PAY_TIMEOUT, 0, 0);

        // Reset in the 4th HOLD cycle must act immediately, not at the next edge.
        req     = 1'b1;
        seat_id = 4'd9;
        step();
        req = 1'b0;
        for (int h = 1; h <= 4; h++) step();
        chk_out("hold4", 1, 0, 0, 0, model_map | 16'h0200);
        rst = 1'b1;
        #1;
        model_map = '0;
        chk_out("async_rst", 0, 0, 0, 0, model_map);
        @(negedge clk);
        rst = 1'b0;
        transact(2, 1, 0, 0);

        repeat (30) begin
            transact(int'($urandom_range(0, 15)), int'($urandom_range(0, 10)),
                     int'($urandom_range(0, 10)), 1'b0);
        end

        for (int s = 0; s < NSEATS; s++) begin
            if (!model_map[s]) transact(s, 1, 0, 0);
        end
        chk("full_free", 32'(seats_free), 32'd0);
        transact(0, 1, 0, 0);
        transact(int'($urandom_range(0, 15)), 1, 0, 0);
        chk("full_free_after", 32'(seats_free), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
